// File: rtl/lift_pkg.sv
// Shared floor codes, request indices and dwell-state types for the lift call panel.
package lift_pkg;

  localparam int unsigned NUM_FLOORS = 4;
  localparam int unsigned FLOOR_W    = 3;
  localparam int unsigned IDX_W      = 2;

  localparam logic [FLOOR_W-1:0] FL_A  = 3'd0;
  localparam logic [FLOOR_W-1:0] FL_BU = 3'd1;
  localparam logic [FLOOR_W-1:0] FL_BD = 3'd2;
  localparam logic [FLOOR_W-1:0] FL_CU = 3'd3;
  localparam logic [FLOOR_W-1:0] FL_CD = 3'd4;
  localparam logic [FLOOR_W-1:0] FL_D  = 3'd5;

  localparam int unsigned IDX_A = 0;
  localparam int unsigned IDX_B = 1;
  localparam int unsigned IDX_C = 2;
  localparam int unsigned IDX_D = 3;

  typedef enum logic {
    IDLE,
    DWELL
  } dwell_state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } floor_dec_t;

  // Up/down variants of B and C collapse onto one physical floor; 6/7 are not floors.
  function automatic floor_dec_t decode_floor(input logic [FLOOR_W-1:0] code);
    floor_dec_t d;
    d.valid = 1'b1;
    d.idx   = '0;
    case (code)
      FL_A:         d.idx = IDX_W'(IDX_A);
      FL_BU, FL_BD: d.idx = IDX_W'(IDX_B);
      FL_CU, FL_CD: d.idx = IDX_W'(IDX_C);
      FL_D:         d.idx = IDX_W'(IDX_D);
      default:      d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lift_call_panel_if.sv
// Button/floor inputs and request/status outputs between the pads, panel and lift FSM.
interface lift_call_panel_if;
  import lift_pkg::*;

  logic [NUM_FLOORS-1:0] btn;
  logic [FLOOR_W-1:0]    floor;
  logic                  ra;
  logic                  rb;
  logic                  rc;
  logic                  rd;
  logic                  door_open;
  logic                  floor_err;

  modport master (
    output btn, floor,
    input  ra, rb, rc, rd, door_open, floor_err
  );

  modport slave (
    input  btn, floor,
    output ra, rb, rc, rd, door_open, floor_err
  );

endinterface

// File: rtl/lift_btn_debounce.sv
// One call button: 2-FF synchroniser, level debouncer and rising-edge press pulse.
module lift_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_c
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // A sample equal to the accepted level restarts the count, so only an unbroken run switches it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt >= CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press_c = level & ~level_d;

endmodule

// File: rtl/lift_call_panel.sv
// Latches debounced call presses as floor requests and clears each one after the car dwells there.
module lift_call_panel
  import lift_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned DWELL_CYCLES    = 3
) (
  input  logic               clk,
  input  logic               rst,
  lift_call_panel_if.slave   bus
);

  localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);

  logic [NUM_FLOORS-1:0] press_c;
  floor_dec_t            dec_c;

  dwell_state_e          state_q, state_n;
  logic [DW-1:0]         cnt_q, cnt_n;
  logic [IDX_W-1:0]      cur_q, cur_n;
  logic [NUM_FLOORS-1:0] req_q, req_n;
  logic                  door_q, door_n;
  logic                  err_q, err_n;

  for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
    lift_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn     (bus.btn[i]),
      .press_c (press_c[i])
    );
  end

  assign dec_c = decode_floor(bus.floor);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      req_q   <= '0;
      door_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      cur_q   <= cur_n;
      req_q   <= req_n;
      door_q  <= door_n;
      err_q   <= err_n;
    end
  end

  // A press always sets its request; at the dwell floor it also restarts the door timer.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    cur_n   = cur_q;
    door_n  = door_q;
    err_n   = err_q;
    req_n   = req_q | press_c;

    if (!dec_c.valid) begin
      err_n = 1'b1;
    end

    case (state_q)
      IDLE: begin
        cnt_n  = '0;
        door_n = 1'b0;
        if (dec_c.valid && req_q[dec_c.idx]) begin
          state_n = DWELL;
          cnt_n   = DW'(1);
          door_n  = 1'b1;
          cur_n   = dec_c.idx;
        end
      end
      DWELL: begin
        if (!dec_c.valid || (dec_c.idx != cur_q)) begin
          state_n = IDLE;
          cnt_n   = '0;
          door_n  = 1'b0;
        end else if (press_c[cur_q]) begin
          cnt_n = DW'(1);
        end else if (cnt_q >= DW'(DWELL_CYCLES)) begin
          req_n[cur_q] = 1'b0;
          state_n      = IDLE;
          cnt_n        = '0;
          door_n       = 1'b0;
        end else begin
          cnt_n = cnt_q + DW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        door_n  = 1'b0;
      end
    endcase
  end

  assign bus.ra        = req_q[IDX_A];
  assign bus.rb        = req_q[IDX_B];
  assign bus.rc        = req_q[IDX_C];
  assign bus.rd        = req_q[IDX_D];
  assign bus.door_open = door_q;
  assign bus.floor_err = err_q;

endmodule
